// File: rtl/event_stream_serializer.sv
// event_stream_serializer: frames spike flags and event codes into checksummed byte packets
module event_stream_serializer #(
  parameter int NUM_UNITS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_UNITS-1:0]   spike_detection_array,
  input  logic [2*NUM_UNITS-1:0] event_out_array,
  output logic [7:0]             serial_data_out,
  output logic                   serial_valid,
  input  logic                   serial_ready,
  output logic                   busy,
  output logic                   overflow
);
  localparam int EB = NUM_UNITS / 4;
  localparam int SB = NUM_UNITS / 8;
  typedef enum logic [2:0] {IDLE, SYNC, SEQ, EVT, SPK, CSUM} state_t;
  state_t state, state_n;
  logic [2*NUM_UNITS-1:0] snap_evt, pend_evt, t_evt, evt_sh;
  logic [NUM_UNITS-1:0]   snap_spk, pend_spk, t_spk, spk_sh, clash;
  logic [7:0]             seq, csum;
  logic [3:0]             cnt;
  logic                   xfer, trig, last;
  assign t_evt = pend_evt | event_out_array;
  assign t_spk = pend_spk | spike_detection_array;
  assign trig = |t_evt || |t_spk;
  assign xfer = serial_valid && serial_ready;
  assign evt_sh = snap_evt >> {cnt, 3'b000};
  assign spk_sh = snap_spk >> {cnt, 3'b000};
  assign last = (state == EVT) ? cnt == 4'(EB - 1) : cnt == 4'(SB - 1);
  assign serial_valid = state != IDLE;
  assign busy = state != IDLE;
  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_clash
    assign clash[i] = |pend_evt[2*i +: 2] && |event_out_array[2*i +: 2];
  end
  // byte presented for the current state; state only moves on a transfer so this holds under stall
  always_comb begin
    serial_data_out = state == SYNC ? 8'hA5 :
                      state == SEQ  ? seq :
                      state == EVT  ? evt_sh[7:0] :
                      state == SPK  ? spk_sh[7:0] :
                      state == CSUM ? csum : 8'h00;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // next-state: IDLE starts on any captured content, other states advance per transferred byte
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = trig ? SYNC : IDLE;
    else if (xfer) begin
      unique case (state)
        SYNC:    state_n = SEQ;
        SEQ:     state_n = EVT;
        EVT:     state_n = last ? SPK : EVT;
        SPK:     state_n = last ? CSUM : SPK;
        default: state_n = IDLE;
      endcase
    end
  end
  // snapshot/pending capture, checksum, byte counter, sequence number and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_evt <= '0;
      snap_spk <= '0;
      pend_evt <= '0;
      pend_spk <= '0;
      seq      <= '0;
      csum     <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (trig) begin
          snap_evt <= t_evt;
          snap_spk <= t_spk;
          pend_evt <= '0;
          pend_spk <= '0;
          csum     <= '0;
        end
      end else begin
        pend_evt <= t_evt;
        pend_spk <= t_spk;
        if (|clash) overflow <= 1'b1;
      end
      if (xfer) begin
        csum <= csum ^ serial_data_out;
        cnt  <= ((state == EVT || state == SPK) && !last) ? cnt + 4'd1 : 4'd0;
        if (state == CSUM) seq <= seq + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_event_stream_serializer.sv
// tb_event_stream_serializer: directed checks of packet framing, stall, accumulation, wrap and reset
module tb_event_stream_serializer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  spk = '0;
  logic [15:0] evt = '0;
  logic [7:0]  data;
  logic        valid, ready = 1'b1, busy, overflow;
  int total = 0;
  int bad = 0;

  event_stream_serializer #(.NUM_UNITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .spike_detection_array(spk), .event_out_array(evt),
    .serial_data_out(data), .serial_valid(valid), .serial_ready(ready),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    rst_n = 1'b0;
    evt = '0;
    spk = '0;
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse(input logic [15:0] e, input logic [7:0] s);
    @(posedge clk);
    #1 evt = e; spk = s;
    @(posedge clk);
    #1 evt = '0; spk = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    total++;
    if ({valid, data, busy, overflow} !== 11'b0) begin
      bad++;
      $display("FAIL reset: valid=%b data=%h busy=%b ovf=%b, want all 0", valid, data, busy, overflow);
    end
    do_reset();
  endtask

  task automatic test_single;
    logic [7:0] exp [6] = '{8'hA5, 8'h00, 8'h04, 8'h00, 8'h02, 8'hA3};
    do_reset();
    pulse(16'h0004, 8'h02);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (valid !== 1'b1 || data !== exp[c] || busy !== 1'b1) begin
        bad++;
        $display("FAIL single byte%0d: valid=%b busy=%b data=%h, want 1 1 %h", c, valid, busy, data, exp[c]);
      end
    end
    @(negedge clk);
    total++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single end: valid=%b busy=%b, want 0 0", valid, busy);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp [9] = '{8'hA5, 8'h00, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h02, 8'hA3};
    do_reset();
    pulse(16'h0004, 8'h02);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
      total++;
      if (valid !== 1'b1 || data !== exp[c]) begin
        bad++;
        $display("FAIL stall cyc%0d: valid=%b data=%h, want 1 %h", c, valid, data, exp[c]);
      end
    end
    @(negedge clk);
    ready = 1'b1;
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL stall end: valid=%b, want 0", valid);
    end
  endtask

  task automatic test_event_during_busy;
    logic [8:0] exp [13] = '{9'h1A5, 9'h100, 9'h104, 9'h100, 9'h102, 9'h1A3, 9'h000,
                             9'h1A5, 9'h101, 9'h180, 9'h100, 9'h100, 9'h124};
    do_reset();
    pulse(16'h0004, 8'h02);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      evt = (c == 1) ? 16'h0080 : 16'h0000;
      total++;
      if ({valid, data} !== exp[c]) begin
        bad++;
        $display("FAIL busy_evt cyc%0d: valid,data=%h, want %h", c, {valid, data}, exp[c]);
      end
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL busy_evt ovf: got %b, want 0", overflow);
    end
  endtask

  task automatic test_overflow;
    logic [8:0] exp [13] = '{9'h1A5, 9'h100, 9'h101, 9'h100, 9'h100, 9'h1A4, 9'h000,
                             9'h1A5, 9'h101, 9'h10C, 9'h100, 9'h100, 9'h1A8};
    do_reset();
    pulse(16'h0001, 8'h00);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      evt = (c == 1) ? 16'h0004 : (c == 2) ? 16'h0008 : 16'h0000;
      total++;
      if ({valid, data} !== exp[c]) begin
        bad++;
        $display("FAIL ovf cyc%0d: valid,data=%h, want %h", c, {valid, data}, exp[c]);
      end
      if (c == 2) begin
        total++;
        if (overflow !== 1'b0) begin
          bad++;
          $display("FAIL ovf early: got %b, want 0", overflow);
        end
      end
    end
    repeat (3) @(negedge clk);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf sticky: got %b, want 1", overflow);
    end
  endtask

  task automatic test_seq_wrap;
    logic [7:0] got [6];
    logic [7:0] sq;
    do_reset();
    for (int p = 0; p < 257; p++) begin
      sq = p[7:0];
      pulse(16'h0001, 8'h00);
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        got[c] = valid ? data : 8'hxx;
      end
      total++;
      if (got[0] !== 8'hA5 || got[1] !== sq || got[2] !== 8'h01 || got[5] !== (8'hA4 ^ sq)) begin
        bad++;
        $display("FAIL wrap pkt%0d: sync=%h seq=%h evt=%h csum=%h, want A5 %h 01 %h",
                 p, got[0], got[1], got[2], got[5], sq, 8'hA4 ^ sq);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] got [6];
    do_reset();
    pulse(16'h0004, 8'h02);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      evt = (c == 1) ? 16'h0040 : 16'h0000;
    end
    total++;
    if (valid !== 1'b1 || data !== 8'h00) begin
      bad++;
      $display("FAIL mid evt1: valid=%b data=%h, want 1 00", valid, data);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid async: valid=%b busy=%b, want 0 0", valid, busy);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (valid !== 1'b0) begin
        bad++;
        $display("FAIL mid discard: valid=%b, want 0", valid);
      end
    end
    pulse(16'h0001, 8'h00);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      got[c] = valid ? data : 8'hxx;
    end
    total++;
    if (got[0] !== 8'hA5 || got[1] !== 8'h00 || got[5] !== 8'hA4) begin
      bad++;
      $display("FAIL mid restart: sync=%h seq=%h csum=%h, want A5 00 A4", got[0], got[1], got[5]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_event_during_busy();
    test_overflow();
    test_seq_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
